// File: rtl/bp_btb_bht_if.sv
// Fetch-lookup and EX-resolve signal bundle for the branch target buffer / history table.
// The pipeline drives through the master modport; the predictor sits on the slave modport.
interface bp_btb_bht_if;
    // Fetch-stage lookup
    logic [31:0] pc_i;
    logic        hit_o;
    logic        pred_taken_o;
    logic [31:0] predicted_pc_o;

    // EX-stage resolution
    logic        ex_valid_i;
    logic        ex_is_branch_i;
    logic        ex_is_jump_i;
    logic        ex_taken_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_target_i;
    logic        ex_pred_taken_i;
    logic [31:0] ex_pred_pc_i;
    logic        flush_i;

    // Redirect and performance counters
    logic        mispredict_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] br_cnt_o;
    logic [31:0] mispred_cnt_o;

    modport master (
        output pc_i, ex_valid_i, ex_is_branch_i, ex_is_jump_i, ex_taken_i,
               ex_pc_i, ex_target_i, ex_pred_taken_i, ex_pred_pc_i, flush_i,
        input  hit_o, pred_taken_o, predicted_pc_o, mispredict_o, redirect_pc_o,
               br_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  pc_i, ex_valid_i, ex_is_branch_i, ex_is_jump_i, ex_taken_i,
               ex_pc_i, ex_target_i, ex_pred_taken_i, ex_pred_pc_i, flush_i,
        output hit_o, pred_taken_o, predicted_pc_o, mispredict_o, redirect_pc_o,
               br_cnt_o, mispred_cnt_o
    );
endinterface

// File: rtl/bp_btb_bht.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters,
// EX-stage mispredict detection/redirect and resolved/mispredicted performance counters.
module bp_btb_bht #(
    parameter int IDX_W = 5,
    parameter int TAG_W = 20,
    parameter int CNT_W = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    bp_btb_bht_if.slave   bus
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (TAG_W + IDX_W + 2 > 32) begin : g_bad_geometry
        $error("bp_btb_bht: TAG_W + IDX_W + 2 must not exceed 32");
    end
    if (CNT_W < 1 || CNT_W > 4) begin : g_bad_cnt_w
        $error("bp_btb_bht: CNT_W must be in 1..4");
    end

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [CNT_W-1:0] cnt;
    } entry_t;

    entry_t      table_q [DEPTH];
    entry_t      table_d [DEPTH];
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    // Bits between the index and the tag never reach the table, so aliasing is accepted.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.pc_i, bus.ex_pc_i};

    // ---------------- fetch-stage lookup (pre-edge table contents, no bypass)
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    entry_t           lk_entry;

    assign lk_idx   = bus.pc_i[IDX_W+1:2];
    assign lk_tag   = bus.pc_i[31 -: TAG_W];
    assign lk_entry = table_q[lk_idx];

    assign bus.hit_o          = lk_entry.valid && (lk_entry.tag == lk_tag);
    assign bus.pred_taken_o   = bus.hit_o && lk_entry.cnt[CNT_W-1];
    assign bus.predicted_pc_o = lk_entry.target;

    // ---------------- EX-stage resolution
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    entry_t           ex_entry;
    logic             ex_hit;
    logic             upd_qual;
    logic             act_taken;

    assign ex_idx    = bus.ex_pc_i[IDX_W+1:2];
    assign ex_tag    = bus.ex_pc_i[31 -: TAG_W];
    assign ex_entry  = table_q[ex_idx];
    assign ex_hit    = ex_entry.valid && (ex_entry.tag == ex_tag);
    assign upd_qual  = bus.ex_valid_i && (bus.ex_is_branch_i || bus.ex_is_jump_i);
    assign act_taken = bus.ex_is_jump_i || bus.ex_taken_i;

    assign bus.mispredict_o  = upd_qual &&
                               ((act_taken != bus.ex_pred_taken_i) ||
                                (act_taken && (bus.ex_pred_pc_i != bus.ex_target_i)));
    assign bus.redirect_pc_o = act_taken ? bus.ex_target_i : (bus.ex_pc_i + 32'd4);

    // ---------------- next-state table contents
    entry_t new_entry;
    logic   wr_en;

    // NOTE: combinational blocks assign every variable a default first and use blocking
    // assignments, so no path leaves a value held over and no latch is inferred.
    always_comb begin
        new_entry = ex_entry;
        wr_en     = 1'b0;
        if (upd_qual) begin
            if (ex_hit) begin
                wr_en = 1'b1;
                if (act_taken) begin
                    new_entry.target = bus.ex_target_i;
                    if (bus.ex_is_jump_i || (ex_entry.cnt == CNT_MAX)) begin
                        new_entry.cnt = CNT_MAX;
                    end else begin
                        new_entry.cnt = ex_entry.cnt + CNT_ONE;
                    end
                end else if (ex_entry.cnt != '0) begin
                    new_entry.cnt = ex_entry.cnt - CNT_ONE;
                end
            end else if (act_taken) begin
                wr_en            = 1'b1;
                new_entry.valid  = 1'b1;
                new_entry.tag    = ex_tag;
                new_entry.target = bus.ex_target_i;
                new_entry.cnt    = bus.ex_is_jump_i ? CNT_MAX : CNT_WEAK;
            end
        end

        table_d = table_q;
        // Flush takes priority over a coincident update: nothing is written that cycle.
        if (bus.flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_d[i].valid = 1'b0;
            end
        end else if (wr_en) begin
            table_d[ex_idx] = new_entry;
        end
    end

    always_comb begin
        br_cnt_d      = br_cnt_q + {31'd0, upd_qual};
        mispred_cnt_d = mispred_cnt_q + {31'd0, bus.mispredict_o};
    end

    // NOTE: the table is built from flops, not RAM, so every field can be cleared by the
    // asynchronous reset; an update in flight when reset arrives is simply lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            table_q       <= table_d;
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bus.br_cnt_o      = br_cnt_q;
    assign bus.mispred_cnt_o = mispred_cnt_q;

endmodule
